ctrl_pipeline: RTL
==================

CTRL_PIPELINE -- requirements
Module: ctrl_pipeline

Interface
REQ-001 SHALL have clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have reset  in  1  synchronous, active-high reset, sampled on rising clk edge.
REQ-003 SHALL have RegWrite_ID, MemtoReg_ID, Branch_ID, MemRead_ID, MemWrite_ID, RegDst_ID, ALUSrc_ID  in  1 each  decoded ID-stage controls.
REQ-004 SHALL have ALUOp_ID  in  2  decoded ALU operation class.
REQ-005 SHALL have Rs_ID, Rt_ID, Rd_ID  in  5 each  register fields of the ID-stage instruction.
REQ-006 SHALL have Zero_EX  in  1  ALU zero flag of the EX-stage instruction.
REQ-007 SHALL have RegDst_EX, ALUSrc_EX  out  1 each, and ALUOp_EX  out  2  EX-stage controls.
REQ-008 SHALL have Branch_MEM, MemRead_MEM, MemWrite_MEM  out  1 each  MEM-stage controls.
REQ-009 SHALL have RegWrite_WB, MemtoReg_WB  out  1 each, and WriteReg_WB  out  5  WB-stage controls and destination.
REQ-010 SHALL have Stall_ID  out  1  hold PC and IF/ID; PCSrc_MEM  out  1  take branch target; Flush_IF  out  1  discard IF/ID contents.

Function
REQ-011 SHALL hold three control registers: ID/EX (all ID controls, Rt, Rd), EX/MEM (M+WB controls, WriteReg, Zero), MEM/WB (WB controls, WriteReg).
REQ-012 SHALL give one-cycle latency per stage: ID values appear on EX outputs 1 cycle later, MEM 2 cycles, WB 3 cycles.
REQ-013 SHALL compute WriteReg_EX = RegDst_EX ? Rd_EX : Rt_EX, captured into EX/MEM, then MEM/WB.
REQ-014 SHALL capture Zero_EX into EX/MEM as Zero_MEM alongside Branch.
REQ-015 SHALL drive PCSrc_MEM = Branch_MEM & Zero_MEM combinationally.
REQ-016 SHALL assert Stall_ID combinationally when MemRead_EX=1, Rt_EX!=0, and (Rt_EX==Rs_ID or Rt_EX==Rt_ID), and PCSrc_MEM=0.
REQ-017 SHALL, on a stall cycle, load a bubble (all controls 0, Rt/Rd 0) into ID/EX while EX/MEM and MEM/WB advance normally.
REQ-018 SHALL, when PCSrc_MEM=1, assert Flush_IF and load bubbles into both ID/EX and EX/MEM on that edge; MEM/WB advances normally.
REQ-019 SHALL give branch flush priority over stall: Stall_ID=0 whenever PCSrc_MEM=1.
REQ-020 SHALL stall at most one cycle per load: after the bubble, MemRead_EX=0 and Stall_ID deasserts unless a new hazard arises.
REQ-021 SHALL pass X-valued don't-care inputs (MemtoReg, RegDst on SW/BEQ) unmodified except in bubbles, which are forced to 0.
REQ-022 SHALL keep the hazard compare purely on register numbers; no forwarding logic inside this block.

Reset
REQ-023 SHALL, with reset=1 at a rising edge, clear all three pipeline registers to 0 (all control outputs, WriteReg_WB, Zero_MEM = 0).
REQ-024 SHALL, while reset=1, force Stall_ID=0, PCSrc_MEM=0, Flush_IF=0.
REQ-025 SHALL let reset override stall and flush when asserted mid-operation; first post-reset edge loads ID inputs normally.

Verification
REQ-026 R-type (RegWrite=1, RegDst=1, ALUOp=10, Rd=5) in ID for 1 cycle -> ALUOp_EX=10 at +1; RegWrite_WB=1, WriteReg_WB=5 at +3.
REQ-027 LW Rt=8 in EX, ID Rs=8 -> Stall_ID=1 for exactly 1 cycle; next EX controls all 0; LW reaches WB with MemtoReg_WB=1, WriteReg_WB=8.
REQ-028 LW Rt=0 in EX, ID Rs=0 -> Stall_ID stays 0.
REQ-029 BEQ with Zero_EX=1 -> next cycle PCSrc_MEM=1, Flush_IF=1; following cycle EX and MEM controls all 0; BEQ with Zero_EX=0 -> PCSrc_MEM=0.
REQ-030 Taken branch in MEM same cycle as load-use hazard -> Stall_ID=0, PCSrc_MEM=1, both bubbles inserted.
REQ-031 Reset asserted one cycle while LW in MEM -> all outputs 0 after edge; LW does not reach WB.

Source files
------------

// File: rtl/ctrl_pipeline.sv
// Control-path pipeline registers (ID/EX, EX/MEM, MEM/WB) with load-use
// stall detection and taken-branch flush for a classic 5-stage MIPS core.
// There are no handshakes: every stage advances on every clock edge, and
// hazards are handled by replacing a stage's contents with a bubble.
module ctrl_pipeline (
  input  logic       clk,
  input  logic       reset,
  // ID-stage decoded controls and register fields
  input  logic       RegWrite_ID,
  input  logic       MemtoReg_ID,
  input  logic       Branch_ID,
  input  logic       MemRead_ID,
  input  logic       MemWrite_ID,
  input  logic       RegDst_ID,
  input  logic       ALUSrc_ID,
  input  logic [1:0] ALUOp_ID,
  input  logic [4:0] Rs_ID,
  input  logic [4:0] Rt_ID,
  input  logic [4:0] Rd_ID,
  // ALU zero flag for the instruction currently in EX
  input  logic       Zero_EX,
  // EX-stage controls
  output logic       RegDst_EX,
  output logic       ALUSrc_EX,
  output logic [1:0] ALUOp_EX,
  // MEM-stage controls
  output logic       Branch_MEM,
  output logic       MemRead_MEM,
  output logic       MemWrite_MEM,
  // WB-stage controls and destination
  output logic       RegWrite_WB,
  output logic       MemtoReg_WB,
  output logic [4:0] WriteReg_WB,
  // hazard outputs
  output logic       Stall_ID,
  output logic       PCSrc_MEM,
  output logic       Flush_IF
);

  // ID/EX contents that are not exported as ports
  logic       regwrite_ex;
  logic       memtoreg_ex;
  logic       branch_ex;
  logic       memread_ex;
  logic       memwrite_ex;
  logic [4:0] rt_ex;
  logic [4:0] rd_ex;

  // EX/MEM contents that are not exported as ports
  logic       regwrite_mem;
  logic       memtoreg_mem;
  logic [4:0] writereg_mem;
  logic       zero_mem;

  // combinational hazard/control terms
  logic [4:0] write_reg_ex;
  logic       load_use;
  logic       bubble_id_ex;

  // Destination select, branch decision and load-use detection.
  // Reset masks all hazard outputs; a taken branch masks the stall because
  // the instruction that would have stalled is about to be flushed anyway.
  always_comb begin
    write_reg_ex = rt_ex;
    load_use     = 1'b0;
    PCSrc_MEM    = 1'b0;
    Stall_ID     = 1'b0;
    Flush_IF     = 1'b0;
    bubble_id_ex = 1'b0;
    if (RegDst_EX) begin
      write_reg_ex = rd_ex;
    end
    if (memread_ex && (rt_ex != 5'd0) && ((rt_ex == Rs_ID) || (rt_ex == Rt_ID))) begin
      load_use = 1'b1;
    end
    if (!reset) begin
      PCSrc_MEM = Branch_MEM & zero_mem;
      Stall_ID  = load_use & ~PCSrc_MEM;
      Flush_IF  = PCSrc_MEM;
    end
    bubble_id_ex = Stall_ID | PCSrc_MEM;
  end

  // ID/EX register: bubble on stall or taken branch, else capture ID controls.
  always_ff @(posedge clk) begin
    if (reset || bubble_id_ex) begin
      regwrite_ex <= 1'b0;
      memtoreg_ex <= 1'b0;
      branch_ex   <= 1'b0;
      memread_ex  <= 1'b0;
      memwrite_ex <= 1'b0;
      RegDst_EX   <= 1'b0;
      ALUSrc_EX   <= 1'b0;
      ALUOp_EX    <= 2'b00;
      rt_ex       <= 5'd0;
      rd_ex       <= 5'd0;
    end else begin
      regwrite_ex <= RegWrite_ID;
      memtoreg_ex <= MemtoReg_ID;
      branch_ex   <= Branch_ID;
      memread_ex  <= MemRead_ID;
      memwrite_ex <= MemWrite_ID;
      RegDst_EX   <= RegDst_ID;
      ALUSrc_EX   <= ALUSrc_ID;
      ALUOp_EX    <= ALUOp_ID;
      rt_ex       <= Rt_ID;
      rd_ex       <= Rd_ID;
    end
  end

  // EX/MEM register: bubble on taken branch (kills the wrong-path EX op).
  always_ff @(posedge clk) begin
    if (reset || PCSrc_MEM) begin
      regwrite_mem <= 1'b0;
      memtoreg_mem <= 1'b0;
      Branch_MEM   <= 1'b0;
      MemRead_MEM  <= 1'b0;
      MemWrite_MEM <= 1'b0;
      writereg_mem <= 5'd0;
      zero_mem     <= 1'b0;
    end else begin
      regwrite_mem <= regwrite_ex;
      memtoreg_mem <= memtoreg_ex;
      Branch_MEM   <= branch_ex;
      MemRead_MEM  <= memread_ex;
      MemWrite_MEM <= memwrite_ex;
      writereg_mem <= write_reg_ex;
      zero_mem     <= Zero_EX;
    end
  end

  // MEM/WB register: always advances; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      RegWrite_WB <= 1'b0;
      MemtoReg_WB <= 1'b0;
      WriteReg_WB <= 5'd0;
    end else begin
      RegWrite_WB <= regwrite_mem;
      MemtoReg_WB <= memtoreg_mem;
      WriteReg_WB <= writereg_mem;
    end
  end

endmodule
